// File: rtl/sha3_job_pkg.sv
// Shared constants and state encodings for the SHA3 job loader.
// Frames are 24 block words followed by the low and high threshold words.
package sha3_job_pkg;

   localparam int JOB_WORDS  = 26;
   localparam int THR_LO_IDX = 24;
   localparam int THR_HI_IDX = 25;
   localparam int IDX_W      = $clog2(JOB_WORDS);

   typedef enum logic [1:0] {
      FILL,
      DISCARD,
      FULL
   } fill_state_e;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN
   } launch_state_e;

endpackage

// File: rtl/sha3_job_launcher.sv
// Hands a buffered job to the scanner, then waits for the scanner to
// acknowledge it by dropping ready before another launch is allowed.
module sha3_job_launcher
   import sha3_job_pkg::*;
#(
   parameter int ARM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_pending,
   input  logic             scanner_ready,
   input  logic             clear_err,
   output logic             xfer,
   output logic             start,
   output logic             busy,
   output logic             arm_timeout_err,
   output logic [CNT_W-1:0] jobs_launched
);

   localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

   launch_state_e    state_q;
   logic [TMO_W-1:0] tmo_q;
   logic             start_q;
   logic             tmo_err_q;
   logic [CNT_W-1:0] jobs_q;

   assign xfer = (state_q == IDLE) & job_pending & scanner_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tmo_q     <= '0;
         start_q   <= 1'b0;
         tmo_err_q <= 1'b0;
         jobs_q    <= '0;
      end else begin
         start_q <= 1'b0;
         if (clear_err) tmo_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  start_q <= 1'b1;
                  jobs_q  <= jobs_q + CNT_W'(1);
                  tmo_q   <= '0;
                  state_q <= ARMED;
               end
            end
            // scanner holds ready high a few cycles after capturing
            ARMED: begin
               if (!scanner_ready) begin
                  state_q <= RUN;
               end else if (tmo_q == TMO_LAST) begin
                  tmo_err_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            RUN: begin
               if (scanner_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign start           = start_q;
   assign busy            = state_q != IDLE;
   assign arm_timeout_err = tmo_err_q;
   assign jobs_launched   = jobs_q;

endmodule

// File: rtl/sha3_job_loader.sv
// Assembles 26-word job frames from a valid/ready stream into a shadow
// buffer and launches each complete job into the nonce scanner.
module sha3_job_loader
   import sha3_job_pkg::*;
#(
   parameter int ARM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              s_ready,
   input  logic              scanner_ready,
   output logic              start,
   output logic [23:0][31:0] blobby,
   output logic [63:0]       threshold,
   output logic              job_pending,
   output logic              busy,
   output logic              frame_err,
   input  logic              clear_err,
   output logic              arm_timeout_err,
   output logic [CNT_W-1:0]  jobs_launched
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(THR_HI_IDX);

   fill_state_e       fill_q;
   logic [IDX_W-1:0]  idx_q;
   logic              frame_err_d, frame_err_q;
   logic [31:0]       shadow_d [JOB_WORDS];
   logic [31:0]       shadow_q [JOB_WORDS];
   logic [23:0][31:0] blobby_d, blobby_q;
   logic [63:0]       thr_d, thr_q;
   logic              hs, wr_en, at_last, err_set, xfer;

   assign hs      = s_valid & s_ready;
   assign wr_en   = hs & (fill_q == FILL);
   assign at_last = idx_q == LAST_IDX;
   // early s_last, or a missing s_last on the final slot
   assign err_set = wr_en & (s_last ^ at_last);

   always_comb begin
      frame_err_d = frame_err_q;
      if (clear_err) frame_err_d = 1'b0;
      if (err_set)   frame_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q      <= FILL;
         idx_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         unique case (fill_q)
            FILL: begin
               if (hs) begin
                  if (s_last || at_last) idx_q <= '0;
                  else                   idx_q <= idx_q + IDX_W'(1);
                  if (s_last && at_last) fill_q <= FULL;
                  else if (at_last)      fill_q <= DISCARD;
               end
            end
            DISCARD: begin
               if (hs && s_last) begin
                  fill_q <= FILL;
                  idx_q  <= '0;
               end
            end
            FULL: begin
               if (xfer) begin
                  fill_q <= FILL;
                  idx_q  <= '0;
               end
            end
            default: fill_q <= FILL;
         endcase
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) shadow_d[idx_q] = s_data;
   end

   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   always_comb begin
      blobby_d = blobby_q;
      thr_d    = thr_q;
      if (xfer) begin
         for (int i = 0; i < THR_LO_IDX; i++) blobby_d[i] = shadow_q[i];
         thr_d = {shadow_q[THR_HI_IDX], shadow_q[THR_LO_IDX]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blobby_q <= '0;
         thr_q    <= '0;
      end else begin
         blobby_q <= blobby_d;
         thr_q    <= thr_d;
      end
   end

   sha3_job_launcher #(
      .ARM_TIMEOUT (ARM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_launcher (
      .clk             (clk),
      .rst             (rst),
      .job_pending     (job_pending),
      .scanner_ready   (scanner_ready),
      .clear_err       (clear_err),
      .xfer            (xfer),
      .start           (start),
      .busy            (busy),
      .arm_timeout_err (arm_timeout_err),
      .jobs_launched   (jobs_launched)
   );

   assign s_ready     = fill_q != FULL;
   assign job_pending = fill_q == FULL;
   assign frame_err   = frame_err_q;
   assign blobby      = blobby_q;
   assign threshold   = thr_q;

endmodule
